// File: rtl/dense_sequencer_if.sv
// Handshake/config and datapath-control bundle between the network controller,
// the dense-layer sequencer and the MAC/memory side.
interface dense_sequencer_if #(
    parameter int LEN_W    = 11,
    parameter int W_ADDR_W = 20
);
    logic                start;
    logic                abort;
    logic [LEN_W-1:0]    cfg_in_len;
    logic [LEN_W-1:0]    cfg_out_len;
    logic [W_ADDR_W-1:0] cfg_w_base;
    logic                cfg_relu;
    logic                busy;
    logic                done;
    logic                cfg_err;
    logic                buf_sel;
    logic                rd_en;
    logic [W_ADDR_W-1:0] w_addr;
    logic [LEN_W-1:0]    b_addr;
    logic [LEN_W-1:0]    a_addr;
    logic                acc_load_bias;
    logic                acc_en;
    logic                res_wr_en;
    logic [LEN_W-1:0]    res_wr_addr;
    logic                res_relu;

    modport master (
        output start, abort, cfg_in_len, cfg_out_len, cfg_w_base, cfg_relu,
        input  busy, done, cfg_err, buf_sel, rd_en, w_addr, b_addr, a_addr,
               acc_load_bias, acc_en, res_wr_en, res_wr_addr, res_relu
    );

    modport slave (
        input  start, abort, cfg_in_len, cfg_out_len, cfg_w_base, cfg_relu,
        output busy, done, cfg_err, buf_sel, rd_en, w_addr, b_addr, a_addr,
               acc_load_bias, acc_en, res_wr_en, res_wr_addr, res_relu
    );
endinterface

// File: rtl/dense_sequencer.sv
// Dense-layer sequencer: walks bias/MAC/drain/write per neuron over a shared MAC and ping-pong buffers.
// Outputs are registered (one cycle behind state); no backpressure, start is ignored while busy.
module dense_sequencer #(
    parameter int MAX_LEN  = 1024,
    parameter int W_ADDR_W = 20,
    parameter int RD_LAT   = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    dense_sequencer_if.slave io_sif
);
    localparam int LEN_W = $clog2(MAX_LEN) + 1;
    localparam logic [LEN_W-1:0]    LEN_ONE    = LEN_W'(1);
    localparam logic [W_ADDR_W-1:0] WP_ONE     = W_ADDR_W'(1);
    localparam logic [1:0]          DRAIN_LAST = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_DRAIN, S_WRITE, S_DONE} state_t;

    state_t              r_state, w_next;
    logic [LEN_W-1:0]    r_in_len, r_out_len, r_o, r_i;
    logic [W_ADDR_W-1:0] r_wp;
    logic                r_relu;
    logic [1:0]          r_drain;

    logic                w_start_ok, w_zero_len, w_abort_busy;
    logic                w_rd_en, w_rd_bias, w_res_wr, w_done, w_busy, w_cfg_err;

    logic                r_rd_en, r_rd_bias, r_res_wr_en, r_res_relu;
    logic                r_done, r_busy, r_cfg_err, r_buf_sel;
    logic [RD_LAT-1:0]   r_lb_dly, r_en_dly;
    logic [W_ADDR_W-1:0] r_w_addr;
    logic [LEN_W-1:0]    r_b_addr, r_a_addr, r_res_wr_addr;

    assign w_start_ok   = io_sif.start && !io_sif.abort;
    assign w_zero_len   = (io_sif.cfg_in_len == '0) || (io_sif.cfg_out_len == '0);
    assign w_abort_busy = io_sif.abort && (r_state != S_IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok && !w_zero_len) w_next = S_BIAS;
            S_BIAS:  w_next = S_MAC;
            S_MAC:   if (r_i == r_in_len - LEN_ONE) w_next = S_DRAIN;
            S_DRAIN: if (r_drain == DRAIN_LAST) w_next = S_WRITE;
            S_WRITE: w_next = (r_o == r_out_len - LEN_ONE) ? S_DONE : S_BIAS;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_abort_busy) w_next = S_IDLE;
    end

    always_comb begin
        w_rd_en   = 1'b0;
        w_rd_bias = 1'b0;
        w_res_wr  = 1'b0;
        w_done    = 1'b0;
        w_busy    = (r_state != S_IDLE);
        w_cfg_err = 1'b0;
        case (r_state)
            S_IDLE:  w_cfg_err = w_start_ok && w_zero_len;
            S_BIAS:  begin w_rd_en = 1'b1; w_rd_bias = 1'b1; end
            S_MAC:   w_rd_en  = 1'b1;
            S_WRITE: w_res_wr = 1'b1;
            S_DONE:  w_done   = 1'b1;
            default: ;
        endcase
    end

    // The running weight pointer replaces base + o*in_len + i; it wraps naturally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_in_len  <= '0;
            r_out_len <= '0;
            r_relu    <= 1'b0;
            r_wp      <= '0;
            r_o       <= '0;
            r_i       <= '0;
            r_drain   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_start_ok) begin
                    r_in_len  <= io_sif.cfg_in_len;
                    r_out_len <= io_sif.cfg_out_len;
                    r_relu    <= io_sif.cfg_relu;
                    r_wp      <= io_sif.cfg_w_base;
                    r_o       <= '0;
                end
                S_BIAS:  begin r_i <= '0; r_drain <= '0; end
                S_MAC:   begin r_i <= r_i + LEN_ONE; r_wp <= r_wp + WP_ONE; end
                S_DRAIN: r_drain <= r_drain + 2'd1;
                S_WRITE: if (r_o != r_out_len - LEN_ONE) r_o <= r_o + LEN_ONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_en       <= 1'b0;
            r_rd_bias     <= 1'b0;
            r_lb_dly      <= '0;
            r_en_dly      <= '0;
            r_res_wr_en   <= 1'b0;
            r_res_relu    <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
            r_cfg_err     <= 1'b0;
            r_buf_sel     <= 1'b0;
            r_w_addr      <= '0;
            r_b_addr      <= '0;
            r_a_addr      <= '0;
            r_res_wr_addr <= '0;
        end else if (w_abort_busy) begin
            // Kill in-flight strobes so the MAC never sees a partial neuron.
            r_rd_en     <= 1'b0;
            r_rd_bias   <= 1'b0;
            r_lb_dly    <= '0;
            r_en_dly    <= '0;
            r_res_wr_en <= 1'b0;
            r_res_relu  <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_rd_en     <= w_rd_en;
            r_rd_bias   <= w_rd_bias;
            r_lb_dly[0] <= r_rd_en && r_rd_bias;
            r_en_dly[0] <= r_rd_en && !r_rd_bias;
            for (int k = 1; k < RD_LAT; k++) begin
                r_lb_dly[k] <= r_lb_dly[k-1];
                r_en_dly[k] <= r_en_dly[k-1];
            end
            r_res_wr_en <= w_res_wr;
            r_res_relu  <= w_res_wr && r_relu;
            r_done      <= w_done;
            r_busy      <= w_busy;
            r_cfg_err   <= w_cfg_err;
            if (r_state == S_DONE) r_buf_sel <= !r_buf_sel;
            if (r_state == S_BIAS) r_b_addr <= r_o;
            if (r_state == S_MAC) begin
                r_a_addr <= r_i;
                r_w_addr <= r_wp;
            end
            if (r_state == S_WRITE) r_res_wr_addr <= r_o;
        end
    end

    assign io_sif.busy          = r_busy;
    assign io_sif.done          = r_done;
    assign io_sif.cfg_err       = r_cfg_err;
    assign io_sif.buf_sel       = r_buf_sel;
    assign io_sif.rd_en         = r_rd_en;
    assign io_sif.w_addr        = r_w_addr;
    assign io_sif.b_addr        = r_b_addr;
    assign io_sif.a_addr        = r_a_addr;
    assign io_sif.acc_load_bias = r_lb_dly[RD_LAT-1];
    assign io_sif.acc_en        = r_en_dly[RD_LAT-1];
    assign io_sif.res_wr_en     = r_res_wr_en;
    assign io_sif.res_wr_addr   = r_res_wr_addr;
    assign io_sif.res_relu      = r_res_relu;
endmodule

// File: tb/tb_dense_sequencer.sv
// Bench for dense_sequencer: two instances (RD_LAT=1 and 3) share one stimulus stream and are
// each compared every cycle against a timeline model derived from the layer schedule arithmetic.
module tb_dense_sequencer;
    localparam int LEN_W    = 11;
    localparam int W_ADDR_W = 20;

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic                s_start = 1'b0;
    logic                s_abort = 1'b0;
    logic [LEN_W-1:0]    s_in = '0;
    logic [LEN_W-1:0]    s_out = '0;
    logic [W_ADDR_W-1:0] s_base = '0;
    logic                s_relu = 1'b0;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int L = (g == 0) ? 1 : 3;

        dense_sequencer_if #(.LEN_W(LEN_W), .W_ADDR_W(W_ADDR_W)) sif ();
        assign sif.start       = s_start;
        assign sif.abort       = s_abort;
        assign sif.cfg_in_len  = s_in;
        assign sif.cfg_out_len = s_out;
        assign sif.cfg_w_base  = s_base;
        assign sif.cfg_relu    = s_relu;

        dense_sequencer #(.MAX_LEN(1024), .W_ADDR_W(W_ADDR_W), .RD_LAT(L)) u_dut (
            .clock   (clock),
            .reset_n (reset_n),
            .io_sif  (sif)
        );

        // Model: m_k counts edges since the start-sampling edge of the active layer.
        bit m_act, m_relu, m_buf, m_cfgerr;
        int m_k, m_in, m_out, m_base;
        int n_done;

        always @(posedge clock or negedge reset_n) begin
            bit idle_now;
            int tot;
            if (!reset_n) begin
                m_act = 0; m_buf = 0; m_cfgerr = 0; m_k = 0;
            end else begin
                m_cfgerr = 0;
                idle_now = 1;
                if (m_act) begin
                    tot = m_out * (m_in + L + 2);
                    if (m_k <= tot) begin
                        idle_now = 0;
                        if (s_abort) m_act = 0;
                        else begin
                            m_k++;
                            if (m_k == tot + 1) m_buf = !m_buf;
                        end
                    end else m_act = 0;
                end
                if (idle_now && s_start && !s_abort) begin
                    if (s_in == '0 || s_out == '0) m_cfgerr = 1;
                    else begin
                        m_act = 1; m_k = 0;
                        m_in = int'(s_in); m_out = int'(s_out);
                        m_base = int'(s_base); m_relu = s_relu;
                    end
                end
            end
        end

        always @(negedge clock) begin
            int P, tot, o, r, kk, ob, rb;
            bit e_bias, e_mac, e_wr, e_lb, e_en, e_done, e_busy;
            e_bias = 0; e_mac = 0; e_wr = 0; e_lb = 0; e_en = 0; e_done = 0; e_busy = 0;
            o = 0; r = 0;
            if (sif.done) n_done++;
            if (m_act) begin
                P   = m_in + L + 2;
                tot = m_out * P;
                e_busy = (m_k >= 1) && (m_k <= tot + 1);
                e_done = (m_k == tot + 1);
                if (m_k >= 1 && m_k <= tot) begin
                    o = (m_k - 1) / P;
                    r = m_k - o * P;
                    e_bias = (r == 1);
                    e_mac  = (r >= 2) && (r <= m_in + 1);
                    e_wr   = (r == P);
                end
                kk = m_k - L;
                if (kk >= 1 && kk <= tot) begin
                    ob = (kk - 1) / P;
                    rb = kk - ob * P;
                    e_lb = (rb == 1);
                    e_en = (rb >= 2) && (rb <= m_in + 1);
                end
            end
            chk($sformatf("strobes_L%0d", L),
                32'({sif.rd_en, sif.acc_load_bias, sif.acc_en, sif.res_wr_en, sif.res_relu,
                     sif.done, sif.busy, sif.cfg_err, sif.buf_sel}),
                32'({e_bias | e_mac, e_lb, e_en, e_wr, e_wr & m_relu,
                     e_done, e_busy, m_cfgerr, m_buf}));
            if (e_bias) chk($sformatf("b_addr_L%0d", L), 32'(sif.b_addr), 32'(o));
            if (e_mac) begin
                chk($sformatf("a_addr_L%0d", L), 32'(sif.a_addr), 32'(r - 2));
                chk($sformatf("w_addr_L%0d", L), 32'(sif.w_addr),
                    32'((m_base + o * m_in + r - 2) & 32'hFFFFF));
            end
            if (e_wr) chk($sformatf("wr_addr_L%0d", L), 32'(sif.res_wr_addr), 32'(o));
        end
    end

    // Leaves the caller one tick after the start-sampling edge.
    task automatic drive_start(input int in_l, input int out_l, input int base, input bit relu);
        @(posedge clock); #1;
        s_start = 1'b1;
        s_in    = LEN_W'(in_l);
        s_out   = LEN_W'(out_l);
        s_base  = W_ADDR_W'(base);
        s_relu  = relu;
        @(posedge clock); #1;
        s_start = 1'b0;
    endtask

    task automatic run_layer(input int in_l, input int out_l, input int base, input bit relu);
        drive_start(in_l, out_l, base, relu);
        repeat (out_l * (in_l + 5) + 3) @(posedge clock);
    endtask

    task automatic pulse_abort_at(input int j);
        repeat (j - 1) @(posedge clock);
        #1 s_abort = 1'b1;
        @(posedge clock); #1 s_abort = 1'b0;
    endtask

    initial begin
        int in_l, out_l, base, mode, j, d0;
        bit relu;

        repeat (3) @(posedge clock);
        chk("rst_outs", 32'({g_lane[0].sif.busy, g_lane[0].sif.rd_en, g_lane[0].sif.buf_sel,
                             g_lane[0].sif.w_addr}), 32'd0);
        #1 reset_n = 1'b1;

        run_layer(3, 2, 'h100, 1'b1);
        chk("buf_after_l1", 32'(g_lane[0].sif.buf_sel), 32'd1);
        run_layer(4, 1, 'h2000, 1'b0);

        drive_start(0, 3, 'h55, 1'b1);
        repeat (4) @(posedge clock);
        drive_start(2, 0, 'h55, 1'b0);
        repeat (4) @(posedge clock);
        chk("zero_len_busy", 32'(g_lane[1].sif.busy), 32'd0);

        drive_start(5, 3, 'h300, 1'b1);
        pulse_abort_at(12);
        repeat (6) @(posedge clock);
        chk("abort_busy", 32'(g_lane[0].sif.busy), 32'd0);
        run_layer(5, 3, 'h400, 1'b0);

        d0 = g_lane[0].n_done;
        drive_start(6, 2, 'h500, 1'b1);
        repeat (4) @(posedge clock);
        #1 s_start = 1'b1; s_in = 11'd2; s_out = 11'd1; s_base = 20'h777;
        @(posedge clock); #1 s_start = 1'b0;
        repeat (2 * 11 + 3) @(posedge clock);
        chk("one_done", 32'(g_lane[0].n_done - d0), 32'd1);

        @(posedge clock); #1 s_start = 1'b1; s_abort = 1'b1; s_in = 11'd2; s_out = 11'd2;
        @(posedge clock); #1 s_start = 1'b0; s_abort = 1'b0;
        repeat (3) @(posedge clock);
        chk("idle_abort_busy", 32'(g_lane[0].sif.busy), 32'd0);

        run_layer(784, 10, 'h1000, 1'b1);
        run_layer(10, 10, 'h9000, 1'b0);

        for (int n = 0; n < 24; n++) begin
            in_l  = $urandom_range(1, 12);
            out_l = $urandom_range(1, 4);
            base  = ($urandom_range(0, 3) == 0) ? ('hFFFF8 + $urandom_range(0, 7))
                                                : $urandom_range(0, 'hFFFFF);
            relu  = 1'($urandom_range(0, 1));
            mode  = $urandom_range(0, 3);
            if (mode == 3) in_l = 0;
            drive_start(in_l, out_l, base, relu);
            j = 0;
            if (mode == 1 || mode == 2) begin
                j = $urandom_range(1, out_l * (in_l + 3));
                if (mode == 1) pulse_abort_at(j);
                else begin
                    repeat (j - 1) @(posedge clock);
                    #1 s_start = 1'b1; s_in = LEN_W'($urandom_range(1, 5));
                    @(posedge clock); #1 s_start = 1'b0;
                end
            end
            repeat (out_l * (in_l + 5) + 3 - j) @(posedge clock);
        end

        if (!g_lane[0].m_buf) run_layer(2, 1, 'h10, 1'b0);
        drive_start(4, 2, 'hABC, 1'b1);
        repeat (8) @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_L3", 32'({g_lane[1].sif.busy, g_lane[1].sif.res_wr_en, g_lane[1].sif.rd_en,
                            g_lane[1].sif.buf_sel, g_lane[1].sif.done, g_lane[1].sif.acc_en,
                            g_lane[1].sif.w_addr}), 32'd0);
        chk("arst_L1", 32'({g_lane[0].sif.busy, g_lane[0].sif.buf_sel, g_lane[0].sif.rd_en,
                            g_lane[0].sif.res_relu, g_lane[0].sif.a_addr}), 32'd0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        run_layer(3, 2, 'h40, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
